// File: rtl/pipe_pkg.sv
// Purpose: shared constants, payload layout and helpers for the pipe_stage_chain
//          register-slice pipeline.
// Contents: default widths, NOP encoding, MEM/WB payload field offsets,
//           a packed view of that payload, and the occupancy-width helper.
package pipe_pkg;

  localparam int unsigned PC_W_DEF      = 32;
  localparam int unsigned PAYLOAD_W_DEF = 101;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  // MEM/WB payload layout (LSB first): instr, pc+8, write-reg, data
  localparam int unsigned INSTR_LSB = 0;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned PC8_LSB   = 32;
  localparam int unsigned PC8_W     = 32;
  localparam int unsigned WREG_LSB  = 64;
  localparam int unsigned WREG_W    = 5;
  localparam int unsigned DATA_LSB  = 69;
  localparam int unsigned DATA_W    = 32;

  // Packed view for callers that build the payload from named fields
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [WREG_W-1:0]  wreg;
    logic [PC8_W-1:0]   pc8;
    logic [INSTR_W-1:0] instr;
  } mem_wb_payload_t;

  // Width of a counter that can hold 0..stages
  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// Purpose: one valid/pc/payload register slice with load, drain, hold and
//          flush behaviour. The ready for this slice is computed by the parent.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               synchronous flush: clear valid, zero payload
//   i_keep_pc           1: pc survives flush/drain; 0: pc is zeroed too
//   i_ready             this slice may take a new value this cycle
//   i_up_valid/pc/payload  upstream beat
//   o_valid_nxt_c       combinational next value of the valid bit
//   o_valid/o_pc/o_payload registered slice contents
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 i_keep_pc,
  input  logic                 i_ready,
  input  logic                 i_up_valid,
  input  logic [PC_W-1:0]      i_up_pc,
  input  logic [PAYLOAD_W-1:0] i_up_payload,
  output logic                 o_valid_nxt_c,
  output logic                 o_valid,
  output logic [PC_W-1:0]      o_pc,
  output logic [PAYLOAD_W-1:0] o_payload
);

  logic                 r_valid;
  logic [PC_W-1:0]      r_pc;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [PC_W-1:0]      w_pc_empty;

  // pc value an emptied slice presents
  assign w_pc_empty = i_keep_pc ? r_pc : '0;

  // Next valid, used by the parent to keep occupancy registered and exact
  always_comb begin
    o_valid_nxt_c = r_valid;
    if (flush) begin
      o_valid_nxt_c = 1'b0;
    end else if (i_ready) begin
      o_valid_nxt_c = i_up_valid;
    end
  end

  // Slice register: reset > flush > load/drain > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_payload <= '0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_pc      <= w_pc_empty;
      r_payload <= '0;
    end else if (i_ready) begin
      if (i_up_valid) begin
        r_valid   <= 1'b1;
        r_pc      <= i_up_pc;
        r_payload <= i_up_payload;
      end else begin
        r_valid   <= 1'b0;
        r_pc      <= w_pc_empty;
        r_payload <= '0;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_pc      = r_pc;
  assign o_payload = r_payload;

endmodule

// File: rtl/pipe_stage_chain.sv
// Purpose: STAGES-deep chain of pipe_slice registers carrying a PC and an
//          opaque payload with valid/ready handshake, stall and flush.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   flush            synchronous flush of all slices
//   in_valid/in_ready/in_pc/in_payload     upstream handshake and beat
//   out_valid/out_ready/out_pc/out_payload downstream handshake and beat
//   occupancy        registered count of valid slices
// Build option: PIPE_FLUSH_KEEP_PC_EN -- when defined, flushed or drained
//   slices keep their last pc (payload still zeroed) so CP0 can read a PC
//   from a bubble. Reset always zeroes pc.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int unsigned STAGES    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PC_W-1:0]               in_pc,
  input  logic [PAYLOAD_W-1:0]          in_payload,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PC_W-1:0]               out_pc,
  output logic [PAYLOAD_W-1:0]          out_payload,
  output logic [occ_width(STAGES)-1:0]  occupancy
);

  localparam int unsigned OCC_W = occ_width(STAGES);

`ifdef PIPE_FLUSH_KEEP_PC_EN
  localparam logic KEEP_PC = 1'b1;
`else
  localparam logic KEEP_PC = 1'b0;
`endif

  logic [STAGES-1:0]    w_valid;
  logic [STAGES-1:0]    w_valid_nxt;
  logic [STAGES-1:0]    w_rdy;
  logic [PC_W-1:0]      w_pc      [STAGES];
  logic [PAYLOAD_W-1:0] w_payload [STAGES];
  logic [OCC_W-1:0]     w_occ_nxt;
  logic [OCC_W-1:0]     r_occupancy;

  // Ready chain: a slice is ready if it is empty or everything after it moves
  always_comb begin
    logic run;
    w_rdy = '0;
    run   = out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      run      = run | ~w_valid[i];
      w_rdy[i] = run;
    end
  end

  assign in_ready = w_rdy[0] & ~flush;

  for (genvar gi = 0; gi < int'(STAGES); gi++) begin : g_slice
    logic                 w_up_valid;
    logic [PC_W-1:0]      w_up_pc;
    logic [PAYLOAD_W-1:0] w_up_payload;

    if (gi == 0) begin : g_head
      assign w_up_valid   = in_valid & ~flush;
      assign w_up_pc      = in_pc;
      assign w_up_payload = in_payload;
    end else begin : g_body
      assign w_up_valid   = w_valid[gi-1];
      assign w_up_pc      = w_pc[gi-1];
      assign w_up_payload = w_payload[gi-1];
    end

    pipe_slice #(
      .PC_W      (PC_W),
      .PAYLOAD_W (PAYLOAD_W)
    ) u_slice (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .i_keep_pc     (KEEP_PC),
      .i_ready       (w_rdy[gi]),
      .i_up_valid    (w_up_valid),
      .i_up_pc       (w_up_pc),
      .i_up_payload  (w_up_payload),
      .o_valid_nxt_c (w_valid_nxt[gi]),
      .o_valid       (w_valid[gi]),
      .o_pc          (w_pc[gi]),
      .o_payload     (w_payload[gi])
    );
  end

  // Popcount of the valid bits as they will be after this edge
  always_comb begin
    w_occ_nxt = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occupancy <= '0;
    end else begin
      r_occupancy <= w_occ_nxt;
    end
  end

  assign occupancy   = r_occupancy;
  assign out_valid   = w_valid[STAGES-1];
  assign out_pc      = w_pc[STAGES-1];
  assign out_payload = w_payload[STAGES-1];

endmodule
